// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle: register indices and control bits in,
// forwarding selects, stall/flush enables, refill request and stall count out.
interface hazard_unit_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [4:0]            Rs1D;
   logic [4:0]            Rs2D;
   logic [4:0]            Rs1E;
   logic [4:0]            Rs2E;
   logic [4:0]            RdE;
   logic [4:0]            RdM;
   logic [4:0]            RdW;
   logic                  RegWriteM;
   logic                  RegWriteW;
   logic [1:0]            ResultSrcE;
   logic                  PCSrcE;
   logic                  MemAccessM;
   logic                  CacheHitM;
   logic                  MemReadyM;
   logic [1:0]            ForwardAE;
   logic [1:0]            ForwardBE;
   logic                  StallF;
   logic                  StallD;
   logic                  StallE;
   logic                  StallM;
   logic                  FlushD;
   logic                  FlushE;
   logic                  FlushW;
   logic                  MemReqM;
   logic [DATA_WIDTH-1:0] StallCount;

   // Pipeline/datapath side
   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
      output MemAccessM, CacheHitM, MemReadyM,
      input  ForwardAE, ForwardBE,
      input  StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushW, MemReqM, StallCount
   );

   // Hazard unit side
   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
      input  MemAccessM, CacheHitM, MemReadyM,
      output ForwardAE, ForwardBE,
      output StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushW, MemReqM, StallCount
   );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit for the five-stage core: execute-stage operand forwarding,
// load-use stall, branch flush, data-memory miss freeze and a saturating
// count of fetch-stall cycles.
module hazard_unit #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   hazard_unit_if.slave hz
);

   typedef enum logic {
      IDLE,
      REFILL
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_load_stall;
   logic                  w_mem_stall;
   logic                  w_stall_f;
   logic [DATA_WIDTH-1:0] r_stall_count;

   // Operand forwarding: memory stage outranks writeback, x0 never forwarded
   always_comb begin
      hz.ForwardAE = 2'b00;
      hz.ForwardBE = 2'b00;
      if (hz.RegWriteM && (hz.RdM != '0) && (hz.RdM == hz.Rs1E))
         hz.ForwardAE = 2'b10;
      else if (hz.RegWriteW && (hz.RdW != '0) && (hz.RdW == hz.Rs1E))
         hz.ForwardAE = 2'b01;
      if (hz.RegWriteM && (hz.RdM != '0) && (hz.RdM == hz.Rs2E))
         hz.ForwardBE = 2'b10;
      else if (hz.RegWriteW && (hz.RdW != '0) && (hz.RdW == hz.Rs2E))
         hz.ForwardBE = 2'b01;
   end

   // Load in execute whose destination is read by the instruction in decode
   always_comb begin
      w_load_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != '0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
   end

   // Miss FSM state register
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // Miss FSM next state plus stall/flush/request outputs; a miss freezes
   // every stage and bubbles writeback, overriding load-use and branch flush
   always_comb begin
      w_next_state = r_state;
      w_mem_stall  = 1'b0;
      hz.MemReqM   = 1'b0;
      hz.StallF    = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.StallM    = 1'b0;
      hz.FlushD    = 1'b0;
      hz.FlushE    = 1'b0;
      hz.FlushW    = 1'b0;

      case (r_state)
         IDLE: begin
            if (hz.MemAccessM && !hz.CacheHitM) begin
               w_mem_stall  = 1'b1;
               w_next_state = REFILL;
            end
         end
         REFILL: begin
            w_mem_stall = 1'b1;
            hz.MemReqM  = 1'b1;
            if (hz.MemReadyM)
               w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase

      if (rst) begin
         hz.MemReqM = 1'b0;
      end else if (w_mem_stall) begin
         hz.StallF = 1'b1;
         hz.StallD = 1'b1;
         hz.StallE = 1'b1;
         hz.StallM = 1'b1;
         hz.FlushW = 1'b1;
      end else begin
         hz.StallF = w_load_stall;
         hz.StallD = w_load_stall;
         hz.FlushD = hz.PCSrcE;
         hz.FlushE = w_load_stall || hz.PCSrcE;
      end
   end

   assign w_stall_f = hz.StallF;

   // Saturating count of cycles with the fetch stage held
   always_ff @(posedge clk) begin
      if (rst)
         r_stall_count <= '0;
      else if (w_stall_f && (r_stall_count != '1))
         r_stall_count <= r_stall_count + DATA_WIDTH'(1);
   end

   assign hz.StallCount = r_stall_count;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, hand-written
// miss/reset/saturation sequences and randomized cycles against a model.
module tb_hazard_unit;

   logic clk = 1'b0;
   logic rst;
   logic rst4;

   always #5 clk = ~clk;

   hazard_unit_if #(.DATA_WIDTH(32)) hz ();
   hazard_unit_if #(.DATA_WIDTH(4))  hz4 ();

   hazard_unit #(.DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   hazard_unit #(.DATA_WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst4),
      .hz  (hz4)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       rwm, rww;
      logic [1:0] rsrc;
      logic       pcs, acc, hit;
      logic [1:0] fa, fb;
      logic [6:0] ctl;   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] ctl_now();
      return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
   endfunction

   task automatic clear_inputs();
      hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
      hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
      hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE = 2'b00;
      hz.PCSrcE = 1'b0; hz.MemAccessM = 1'b0; hz.CacheHitM = 1'b1; hz.MemReadyM = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e; hz.Rs2E = v.rs2e;
      hz.RdE = v.rde; hz.RdM = v.rdm; hz.RdW = v.rdw;
      hz.RegWriteM = v.rwm; hz.RegWriteW = v.rww; hz.ResultSrcE = v.rsrc;
      hz.PCSrcE = v.pcs; hz.MemAccessM = v.acc; hz.CacheHitM = v.hit; hz.MemReadyM = 1'b0;
   endtask

   // Reset pulse spanning one rising edge; branch held high to show that
   // reset masks every stall/flush output
   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      hz.PCSrcE = 1'b1;
      #2;
      check("rst_ctl_forced", ctl_now(), 7'b0);
      check("rst_memreq", hz.MemReqM, 0);
      @(negedge clk);
      rst = 1'b0;
      hz.PCSrcE = 1'b0;
      #2;
      check("post_rst_count", hz.StallCount, 0);
      check("post_rst_memreq", hz.MemReqM, 0);
   endtask

   // Behavioural reference: operand select from the priority rule
   function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic [4:0] rdm,
                                        input logic rwm, input logic [4:0] rdw, input logic rww);
      if (rwm && rdm != 0 && rdm == rs) return 2'b10;
      if (rww && rdw != 0 && rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   bit     m_refill_outstanding;
   longint m_cnt;

   initial begin
      bit     stall, ls, req;
      logic [6:0] exp_ctl;
      int     stall_cycles, req_cycles;

      rst  = 1'b1;
      rst4 = 1'b1;
      clear_inputs();
      hz4.Rs1D = '0; hz4.Rs2D = 5'd7; hz4.Rs1E = '0; hz4.Rs2E = '0;
      hz4.RdE = 5'd7; hz4.RdM = '0; hz4.RdW = '0;
      hz4.RegWriteM = 1'b0; hz4.RegWriteW = 1'b0; hz4.ResultSrcE = 2'b01;
      hz4.PCSrcE = 1'b0; hz4.MemAccessM = 1'b0; hz4.CacheHitM = 1'b1; hz4.MemReadyM = 1'b0;

      //           rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc  pcs acc hit  fa     fb     ctl
      tbl[0]  = '{0,  0,  5,  0,  0,  5,  5,  1, 1, 2'b00, 0, 0, 1, 2'b10, 2'b00, 7'b0000000};
      tbl[1]  = '{0,  0,  5,  0,  0,  5,  5,  0, 1, 2'b00, 0, 0, 1, 2'b01, 2'b00, 7'b0000000};
      tbl[2]  = '{0,  0,  0,  0,  0,  0,  0,  1, 1, 2'b00, 0, 0, 1, 2'b00, 2'b00, 7'b0000000};
      tbl[3]  = '{0,  0,  3,  9,  0,  3,  9,  1, 1, 2'b00, 0, 0, 1, 2'b10, 2'b01, 7'b0000000};
      tbl[4]  = '{0,  0,  4,  9,  0,  9,  9,  1, 1, 2'b00, 0, 0, 1, 2'b00, 2'b10, 7'b0000000};
      tbl[5]  = '{0,  7,  0,  0,  7,  0,  0,  0, 0, 2'b01, 0, 0, 1, 2'b00, 2'b00, 7'b1100010};
      tbl[6]  = '{0,  0,  0,  0,  0,  0,  0,  0, 0, 2'b01, 0, 0, 1, 2'b00, 2'b00, 7'b0000000};
      tbl[7]  = '{7,  0,  0,  0,  7,  0,  0,  0, 0, 2'b10, 0, 0, 1, 2'b00, 2'b00, 7'b0000000};
      tbl[8]  = '{12, 3,  0,  0,  12, 0,  0,  0, 0, 2'b01, 0, 0, 1, 2'b00, 2'b00, 7'b1100010};
      tbl[9]  = '{0,  0,  0,  0,  0,  0,  0,  0, 0, 2'b00, 1, 0, 1, 2'b00, 2'b00, 7'b0000110};
      tbl[10] = '{7,  0,  0,  0,  7,  0,  0,  0, 0, 2'b01, 1, 0, 1, 2'b00, 2'b00, 7'b1100110};
      tbl[11] = '{0,  0,  5,  0,  0,  5,  0,  1, 0, 2'b00, 0, 1, 1, 2'b10, 2'b00, 7'b0000000};
      tbl[12] = '{0,  7,  5,  0,  7,  5,  0,  1, 0, 2'b01, 1, 1, 0, 2'b10, 2'b00, 7'b1111001};

      do_reset();

      // Directed vectors; the miss-detect entry is last since it leaves the FSM in refill
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         apply(tbl[i]);
         #2;
         check($sformatf("tbl%0d_fwdA", i), hz.ForwardAE, tbl[i].fa);
         check($sformatf("tbl%0d_fwdB", i), hz.ForwardBE, tbl[i].fb);
         check($sformatf("tbl%0d_ctl", i), ctl_now(), tbl[i].ctl);
         check($sformatf("tbl%0d_memreq", i), hz.MemReqM, 0);
      end

      // Miss, MemReadyM on third refill cycle, branch held throughout;
      // then a MemReadyM while idle must be ignored
      do_reset();
      hz.PCSrcE = 1'b1;
      stall_cycles = 0;
      req_cycles   = 0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         hz.PCSrcE     = 1'b1;
         hz.CacheHitM  = (k >= 4);
         hz.MemReadyM  = (k == 3) || (k == 5);
         hz.MemAccessM = (k < 5);
         #2;
         stall   = (k < 4);
         req     = (k >= 1) && (k <= 3);
         exp_ctl = stall ? 7'b1111001 : 7'b0000110;
         check($sformatf("miss_k%0d_ctl", k), ctl_now(), exp_ctl);
         check($sformatf("miss_k%0d_memreq", k), hz.MemReqM, req);
         if (hz.StallF) stall_cycles++;
         if (hz.MemReqM) req_cycles++;
         if (k >= 4) check($sformatf("miss_k%0d_count", k), hz.StallCount, 4);
      end
      check("miss_stall_len", stall_cycles, 4);
      check("miss_req_len", req_cycles, 3);

      // Reset asserted in second refill cycle
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         rst           = (k == 2);
         hz.MemAccessM = 1'b1;
         hz.CacheHitM  = (k >= 3);
         hz.MemReadyM  = 1'b0;
         #2;
         check($sformatf("rstmid_k%0d_memreq", k), hz.MemReqM, (k == 1));
         check($sformatf("rstmid_k%0d_ctl", k), ctl_now(), (k < 2) ? 7'b1111001 : 7'b0000000);
         if (k >= 3) check($sformatf("rstmid_k%0d_count", k), hz.StallCount, 0);
      end

      // Saturation on the 4-bit instance under a held load-use stall
      @(negedge clk);
      rst4 = 1'b0;
      #2;
      check("sat_start", hz4.StallCount, 0);
      repeat (10) @(negedge clk);
      #2;
      check("sat_10", hz4.StallCount, 10);
      repeat (10) @(negedge clk);
      #2;
      check("sat_20", hz4.StallCount, 15);
      repeat (2) @(negedge clk);
      #2;
      check("sat_held", hz4.StallCount, 15);

      // Randomized cycles against the reference model
      do_reset();
      m_refill_outstanding = 0;
      m_cnt = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rst           = ($urandom_range(0, 39) == 0);
         hz.Rs1D       = 5'($urandom_range(0, 7));
         hz.Rs2D       = 5'($urandom_range(0, 7));
         hz.Rs1E       = 5'($urandom_range(0, 7));
         hz.Rs2E       = 5'($urandom_range(0, 7));
         hz.RdE        = 5'($urandom_range(0, 7));
         hz.RdM        = 5'($urandom_range(0, 7));
         hz.RdW        = 5'($urandom_range(0, 7));
         hz.RegWriteM  = 1'($urandom_range(0, 1));
         hz.RegWriteW  = 1'($urandom_range(0, 1));
         hz.ResultSrcE = 2'($urandom_range(0, 3));
         hz.PCSrcE     = ($urandom_range(0, 3) == 0);
         hz.MemAccessM = 1'($urandom_range(0, 1));
         hz.CacheHitM  = ($urandom_range(0, 2) != 0);
         hz.MemReadyM  = ($urandom_range(0, 3) == 0);
         #2;
         ls    = (hz.ResultSrcE == 2'b01) && (hz.RdE != 0) &&
                 ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
         stall = m_refill_outstanding || (hz.MemAccessM && !hz.CacheHitM);
         if (rst)        exp_ctl = 7'b0;
         else if (stall) exp_ctl = 7'b1111001;
         else            exp_ctl = {ls, ls, 1'b0, 1'b0, hz.PCSrcE, ls | hz.PCSrcE, 1'b0};
         check("rnd_fwdA", hz.ForwardAE, m_fwd(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW));
         check("rnd_fwdB", hz.ForwardBE, m_fwd(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW));
         check("rnd_ctl", ctl_now(), exp_ctl);
         check("rnd_memreq", hz.MemReqM, m_refill_outstanding && !rst);
         check("rnd_count", hz.StallCount, m_cnt);
         @(posedge clk);
         if (rst) begin
            m_refill_outstanding = 0;
            m_cnt = 0;
         end else begin
            if (exp_ctl[6] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_refill_outstanding) m_refill_outstanding = !hz.MemReadyM;
            else                      m_refill_outstanding = hz.MemAccessM && !hz.CacheHitM;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
